// File: rtl/hazard_controller.sv
// Pipeline hazard control: load-use bubbles, taken-branch flushes, RAW stalls or forwarding.
// Define HAZARD_FORWARD_EN to build operand forwarding; otherwise RAW hazards are resolved by stalling.
module hazard_controller (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRt,
    input  logic [4:0]  exRs,
    input  logic [4:0]  exRt,
    input  logic [4:0]  exDestReg,
    input  logic        exMemRead,
    input  logic        exRegWrite,
    input  logic [4:0]  memDestReg,
    input  logic        memRegWrite,
    input  logic [4:0]  wbDestReg,
    input  logic        wbRegWrite,
    input  logic        memBranchTaken,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        idExBubble,
    output logic        exMemFlush,
    output logic [1:0]  forwardA,
    output logic [1:0]  forwardB,
    output logic [15:0] stallCycles,
    output logic [15:0] flushCount
);

    typedef enum logic [0:0] {StRun, StStall} state_e;

    state_e      state_q, state_d;
    logic [1:0]  stall_left_q, stall_left_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic        load_use;
    logic        raw_ex;
    logic        raw_mem;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_flush;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    assign load_use = exMemRead && (exRt != 5'd0) &&
                      ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

`ifdef HAZARD_FORWARD_EN
    logic unused_stall_inputs;
    assign unused_stall_inputs = ^{exDestReg, exRegWrite};

    assign raw_ex  = 1'b0;
    assign raw_mem = 1'b0;

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (memRegWrite && (memDestReg != 5'd0) && (memDestReg == exRs)) begin
            fwd_a = 2'b10;
        end else if (wbRegWrite && (wbDestReg != 5'd0) && (wbDestReg == exRs)) begin
            fwd_a = 2'b01;
        end
        if (memRegWrite && (memDestReg != 5'd0) && (memDestReg == exRt)) begin
            fwd_b = 2'b10;
        end else if (wbRegWrite && (wbDestReg != 5'd0) && (wbDestReg == exRt)) begin
            fwd_b = 2'b01;
        end
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exRs, wbDestReg, wbRegWrite};

    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;

    // WB writers are absorbed by the write-first regfile and never stall.
    assign raw_ex  = exRegWrite && (exDestReg != 5'd0) &&
                     ((exDestReg == idRs) || (idUsesRt && (exDestReg == idRt)));
    assign raw_mem = memRegWrite && (memDestReg != 5'd0) &&
                     ((memDestReg == idRs) || (idUsesRt && (memDestReg == idRt)));
`endif

    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;

        if (memBranchTaken) begin
            // A taken branch squashes the stalled instruction, so any stall is moot.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = StRun;
            stall_left_d = 2'd0;
        end else begin
            case (state_q)
                StRun: begin
                    if (raw_ex || raw_mem || load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (raw_ex) begin
                            state_d      = StStall;
                            stall_left_d = 2'd2;
                        end else if (raw_mem) begin
                            state_d      = StStall;
                            stall_left_d = 2'd1;
                        end
                    end
                end
                StStall: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (stall_left_q <= 2'd1) begin
                        state_d      = StRun;
                        stall_left_d = 2'd0;
                    end else begin
                        stall_left_d = stall_left_q - 2'd1;
                    end
                end
                default: begin
                    state_d      = StRun;
                    stall_left_d = 2'd0;
                end
            endcase
        end
    end

    // Outputs fall back to free-running fetch while reset is held.
    assign pcWrite    = pc_write | ~reset_n;
    assign ifIdWrite  = if_id_write | ~reset_n;
    assign ifIdFlush  = if_id_flush & reset_n;
    assign idExBubble = id_ex_bubble & reset_n;
    assign exMemFlush = ex_mem_flush & reset_n;
    assign forwardA   = reset_n ? fwd_a : 2'b00;
    assign forwardB   = reset_n ? fwd_b : 2'b00;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pcWrite && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (memBranchTaken && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    assign stallCycles = stall_cycles_q;
    assign flushCount  = flush_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StRun;
            stall_left_q   <= 2'd0;
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            state_q        <= state_d;
            stall_left_q   <= stall_left_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

endmodule
